// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1
  } state_e;

  localparam int         MD_CNT_W = 8;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when an ID source operand is actually read and names the EX destination.
  function automatic logic src_hits(input logic       use_rs,
                                    input logic [4:0] rs,
                                    input logic [4:0] rd);
    return use_rs && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// 32-bit saturating event counter, cleared by synchronous reset.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / mul-div stall controller for the 5-stage core.
// Optional performance counters are built when HAZARD_CTRL_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        MemRead_ex,
  input  logic        md_ex,
  input  logic        branch_taken_ex,
  input  logic        md_done,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        md_start,
`ifdef HAZARD_CTRL_PERF_CNT_EN
  output logic [31:0] load_use_cnt,
  output logic [31:0] md_stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        md_err
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                load_use;

  assign load_use = MemRead_ex && (rd_ex != REG_ZERO) &&
                    (src_hits(use_rs1_id, rs1_id, rd_ex) ||
                     src_hits(use_rs2_id, rs2_id, rd_ex));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_start    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (branch_taken_ex) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (md_ex) begin
          md_start    = 1'b1;
          state_d     = BUSY;
          cnt_d       = '0;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      BUSY: begin
        // md_done takes precedence over the timeout so a late-but-valid result never flags an error.
        if (md_done) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Freeze the front end and bubble every stage while reset is held.
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      md_start    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign md_err = err_q;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic lu_bubble, md_busy, br_flush;

  assign lu_bubble = !reset && (state_q == IDLE) && !branch_taken_ex && !md_ex && load_use;
  assign md_busy   = !reset && (state_q == BUSY);
  assign br_flush  = !reset && (state_q == IDLE) && branch_taken_ex;

  hazard_perf_cnt u_lu_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lu_bubble),
    .cnt   (load_use_cnt)
  );

  hazard_perf_cnt u_md_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (md_busy),
    .cnt   (md_stall_cnt)
  );

  hazard_perf_cnt u_fl_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br_flush),
    .cnt   (flush_cnt)
  );
`endif

endmodule
